multicycle_controller: RTL and testbench

- Multi-cycle sequencer for the RV32I datapath. Steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Drives the control strobes that the single-cycle decoder would otherwise assert combinationally, and handshakes with instruction and data memory.
- Holds the instruction register and a retired-instruction counter.
- Traps on an illegal opcode or a memory timeout.

---
 rtl/multicycle_controller_if.sv | 27 ++
 rtl/multicycle_controller.sv | 223 ++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_controller_if.sv
// rtl/multicycle_controller_if.sv - instruction/data memory handshake bundle
interface multicycle_controller_if;
    logic        imem_req;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ready;

    modport master (
        output imem_req,
        input  imem_ready,
        input  imem_rdata,
        output dmem_req,
        output dmem_we,
        input  dmem_ready
    );

    modport slave (
        input  imem_req,
        output imem_ready,
        output imem_rdata,
        input  dmem_req,
        input  dmem_we,
        output dmem_ready
    );
endinterface

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32I datapath
module multicycle_controller #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    multicycle_controller_if.master mem,
    output logic [31:0]             ir,
    input  logic                    branch_taken,
    output logic                    pc_we,
    output logic                    pc_sel,
    output logic                    rf_we,
    output logic [1:0]              wb_sel,
    output logic                    alu_src,
    output logic [1:0]              alu_op,
    output logic                    retire,
    output logic [CNT_W-1:0]        instret,
    output logic                    trap,
    output logic [1:0]              trap_cause,
    output logic [2:0]              state
);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_e;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    // The wait counter only has to hold 0..TIMEOUT_CYCLES-1: the trap fires
    // from the last value rather than after counting one further.
    localparam int unsigned WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST =
        (TIMEOUT_CYCLES == 0) ? '0 : WAIT_W'(TIMEOUT_CYCLES - 1);

    state_e             state_q, state_d;
    logic [31:0]        ir_q, ir_d;
    logic [CNT_W-1:0]   instret_q, instret_d;
    logic               trap_q, trap_d;
    logic [1:0]         trap_cause_q, trap_cause_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;

    logic       imem_req_c, dmem_req_c, dmem_we_c;
    logic       pc_we_c, pc_sel_c, rf_we_c, alu_src_c, retire_c;
    logic [1:0] wb_sel_c, alu_op_c;

    logic [6:0] opcode;
    logic       is_r, is_i, is_load, is_store, is_branch, is_jal, is_legal;
    logic       rd_nz;
    logic       timeout_hit;

    assign opcode    = ir_q[6:0];
    assign is_r      = (opcode == OPC_R);
    assign is_i      = (opcode == OPC_I);
    assign is_load   = (opcode == OPC_LOAD);
    assign is_store  = (opcode == OPC_STORE);
    assign is_branch = (opcode == OPC_BRANCH);
    assign is_jal    = (opcode == OPC_JAL);
    assign is_legal  = is_r | is_i | is_load | is_store | is_branch | is_jal;
    assign rd_nz     = |ir_q[11:7];

    // This is the last allowed wait cycle; if ready is still low now, trap.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_cnt_q == WAIT_LAST);

    // Next-state, register updates and control strobes decoded from state and IR.
    always_comb begin
        state_d      = state_q;
        ir_d         = ir_q;
        instret_d    = instret_q;
        trap_d       = trap_q;
        trap_cause_d = trap_cause_q;
        wait_cnt_d   = '0;
        imem_req_c   = 1'b0;
        dmem_req_c   = 1'b0;
        dmem_we_c    = 1'b0;
        pc_we_c      = 1'b0;
        pc_sel_c     = 1'b0;
        rf_we_c      = 1'b0;
        wb_sel_c     = 2'd0;
        alu_src_c    = 1'b0;
        alu_op_c     = 2'b00;
        retire_c     = 1'b0;

        case (state_q)
            ST_FETCH: begin
                imem_req_c = 1'b1;
                if (mem.imem_ready) begin
                    ir_d    = mem.imem_rdata;
                    state_d = ST_DECODE;
                end else if (timeout_hit) begin
                    state_d      = ST_TRAP;
                    trap_d       = 1'b1;
                    trap_cause_d = 2'b10;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            ST_DECODE: begin
                if (is_legal) begin
                    state_d = ST_EXEC;
                end else begin
                    state_d      = ST_TRAP;
                    trap_d       = 1'b1;
                    trap_cause_d = 2'b01;
                end
            end
            ST_EXEC: begin
                if (is_r) begin
                    alu_op_c = 2'b10;
                    state_d  = ST_WB;
                end else if (is_i) begin
                    alu_src_c = 1'b1;
                    alu_op_c  = 2'b11;
                    state_d   = ST_WB;
                end else if (is_load || is_store) begin
                    alu_src_c = 1'b1;
                    alu_op_c  = 2'b00;
                    state_d   = ST_MEM;
                end else if (is_branch) begin
                    alu_op_c = 2'b01;
                    pc_we_c  = 1'b1;
                    pc_sel_c = branch_taken;
                    retire_c = 1'b1;
                    state_d  = ST_FETCH;
                end else if (is_jal) begin
                    rf_we_c  = rd_nz;
                    wb_sel_c = 2'd2;
                    pc_we_c  = 1'b1;
                    pc_sel_c = 1'b1;
                    retire_c = 1'b1;
                    state_d  = ST_FETCH;
                end else begin
                    state_d      = ST_TRAP;
                    trap_d       = 1'b1;
                    trap_cause_d = 2'b01;
                end
            end
            ST_MEM: begin
                dmem_req_c = 1'b1;
                dmem_we_c  = is_store;
                if (mem.dmem_ready) begin
                    if (is_store) begin
                        pc_we_c  = 1'b1;
                        retire_c = 1'b1;
                        state_d  = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (timeout_hit) begin
                    state_d      = ST_TRAP;
                    trap_d       = 1'b1;
                    trap_cause_d = 2'b11;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            ST_WB: begin
                rf_we_c  = rd_nz;
                wb_sel_c = is_load ? 2'd1 : 2'd0;
                pc_we_c  = 1'b1;
                retire_c = 1'b1;
                state_d  = ST_FETCH;
            end
            ST_TRAP: begin
                state_d = ST_TRAP;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase

        if (retire_c) begin
            instret_d = instret_q + 1'b1;
        end
    end

    // State, IR, counters and trap flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_FETCH;
            ir_q         <= '0;
            instret_q    <= '0;
            trap_q       <= 1'b0;
            trap_cause_q <= 2'b00;
            wait_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            ir_q         <= ir_d;
            instret_q    <= instret_d;
            trap_q       <= trap_d;
            trap_cause_q <= trap_cause_d;
            wait_cnt_q   <= wait_cnt_d;
        end
    end

    // imem_req is a FETCH output, but must stay low while reset is held.
    assign mem.imem_req = imem_req_c & rst_n;
    assign mem.dmem_req = dmem_req_c;
    assign mem.dmem_we  = dmem_we_c;
    assign pc_we        = pc_we_c;
    assign pc_sel       = pc_sel_c;
    assign rf_we        = rf_we_c;
    assign wb_sel       = wb_sel_c;
    assign alu_src      = alu_src_c;
    assign alu_op       = alu_op_c;
    assign retire       = retire_c;
    assign ir           = ir_q;
    assign instret      = instret_q;
    assign trap         = trap_q;
    assign trap_cause   = trap_cause_q;
    assign state        = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - self-checking bench for multicycle_controller
module tb_multicycle_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        branch_taken;
    logic [31:0] ir;
    logic        pc_we, pc_sel, rf_we, alu_src, retire, trap;
    logic [1:0]  wb_sel, alu_op, trap_cause;
    logic [3:0]  instret;
    logic [2:0]  state;

    multicycle_controller_if bus();

    multicycle_controller #(.TIMEOUT_CYCLES(4), .CNT_W(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem          (bus),
        .ir           (ir),
        .branch_taken (branch_taken),
        .pc_we        (pc_we),
        .pc_sel       (pc_sel),
        .rf_we        (rf_we),
        .wb_sel       (wb_sel),
        .alu_src      (alu_src),
        .alu_op       (alu_op),
        .retire       (retire),
        .instret      (instret),
        .trap         (trap),
        .trap_cause   (trap_cause),
        .state        (state)
    );

    typedef struct packed {
        logic       ireq, dreq, dwe, pwe, psel, rwe;
        logic [1:0] wbs;
        logic       asrc;
        logic [1:0] aop;
        logic       ret, trp;
        logic [1:0] cause;
        logic [2:0] st;
    } out_t;

    typedef struct {
        logic        ir_rdy;
        logic [31:0] rdata;
        logic        d_rdy;
        logic        bt;
        out_t        exp;
        logic [31:0] exp_ir;
        logic [3:0]  exp_cnt;
    } cyc_t;

    typedef struct {
        logic [31:0] instr;
        int          idly;
        int          ddly;
        logic        bt;
        int          cyc;
        logic        rfwe;
        logic [1:0]  wbs;
        logic        psel;
        logic        dwe;
    } vec_t;

    localparam logic [31:0] I_ADD = 32'h002081B3;
    localparam logic [31:0] I_SW  = 32'h0020A223;

    int          checks = 0;
    int          failures = 0;
    cyc_t        trace[$];
    logic [31:0] m_ir;
    logic [3:0]  m_cnt;
    logic [6:0]  legal [6] = '{7'b0110011, 7'b0010011, 7'b0000011,
                               7'b0100011, 7'b1100011, 7'b1101111};
    vec_t        tv [10];
    int          o_ret_at, o_nret, o_npwe;
    logic        o_rfwe, o_dwe, o_psel;
    logic [1:0]  o_wbs;
    out_t        a;
    logic [31:0] rins;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic out_t cur_out();
        out_t r;
        r = '{ireq: bus.imem_req, dreq: bus.dmem_req, dwe: bus.dmem_we, pwe: pc_we,
              psel: pc_sel, rwe: rf_we, wbs: wb_sel, asrc: alu_src, aop: alu_op,
              ret: retire, trp: trap, cause: trap_cause, st: state};
        return r;
    endfunction

    function automatic out_t mk(input logic [2:0] st, input logic ireq, input logic dreq,
                               input logic dwe, input logic trp, input logic [1:0] cause);
        out_t e;
        e = '0;
        e.st = st; e.ireq = ireq; e.dreq = dreq; e.dwe = dwe; e.trp = trp; e.cause = cause;
        return e;
    endfunction

    // Random don't-care inputs; ready outside its own phase must be ignored.
    function automatic cyc_t rnd_cyc();
        cyc_t c;
        c.ir_rdy = 1'($urandom);
        c.rdata  = $urandom;
        c.d_rdy  = 1'($urandom);
        c.bt     = 1'($urandom);
        c.exp    = '0;
        c.exp_ir = '0;
        c.exp_cnt = '0;
        return c;
    endfunction

    task automatic push_c(input cyc_t c, input out_t e);
        c.exp     = e;
        c.exp_ir  = m_ir;
        c.exp_cnt = m_cnt;
        trace.push_back(c);
        if (e.ret) m_cnt = m_cnt + 4'd1;
    endtask

    // Reference: expand one instruction into its cycle-by-cycle outputs.
    task automatic push_instr(input logic [31:0] instr, input int idly, input int ddly, input logic bt);
        logic [6:0] opc;
        logic rd_nz, ld, st, br, jal, r, i;
        cyc_t c;
        out_t e;
        opc = instr[6:0];
        rd_nz = (instr[11:7] != 5'd0);
        r = (opc == 7'b0110011); i = (opc == 7'b0010011); ld = (opc == 7'b0000011);
        st = (opc == 7'b0100011); br = (opc == 7'b1100011); jal = (opc == 7'b1101111);
        for (int k = 0; k <= idly; k++) begin
            c = rnd_cyc();
            c.ir_rdy = (k == idly);
            if (k == idly) c.rdata = instr;
            push_c(c, mk(3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0));
        end
        m_ir = instr;
        push_c(rnd_cyc(), mk(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0));
        c = rnd_cyc();
        e = mk(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        if (r) begin
            e.aop = 2'b10;
        end else if (i) begin
            e.asrc = 1'b1; e.aop = 2'b11;
        end else if (ld || st) begin
            e.asrc = 1'b1; e.aop = 2'b00;
        end else if (br) begin
            c.bt = bt; e.aop = 2'b01; e.pwe = 1'b1; e.psel = bt; e.ret = 1'b1;
        end else if (jal) begin
            e.rwe = rd_nz; e.wbs = 2'd2; e.pwe = 1'b1; e.psel = 1'b1; e.ret = 1'b1;
        end
        push_c(c, e);
        if (ld || st) begin
            for (int k = 0; k <= ddly; k++) begin
                c = rnd_cyc();
                c.d_rdy = (k == ddly);
                e = mk(3'd3, 1'b0, 1'b1, st, 1'b0, 2'd0);
                if (k == ddly && st) begin
                    e.pwe = 1'b1; e.ret = 1'b1;
                end
                push_c(c, e);
            end
        end
        if (r || i || ld) begin
            e = mk(3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
            e.rwe = rd_nz; e.wbs = ld ? 2'd1 : 2'd0; e.pwe = 1'b1; e.ret = 1'b1;
            push_c(rnd_cyc(), e);
        end
    endtask

    task automatic step(input logic ir_rdy, input logic [31:0] rdata, input logic d_rdy, input logic bt);
        @(negedge clk);
        bus.imem_ready = ir_rdy;
        bus.imem_rdata = rdata;
        bus.dmem_ready = d_rdy;
        branch_taken   = bt;
        #1;
        a = cur_out();
    endtask

    task automatic run_trace();
        int n;
        cyc_t c;
        n = 0;
        o_ret_at = 0; o_nret = 0; o_npwe = 0;
        o_rfwe = 1'b0; o_dwe = 1'b0; o_psel = 1'b0; o_wbs = 2'd0;
        while (trace.size() > 0) begin
            c = trace.pop_front();
            n++;
            step(c.ir_rdy, c.rdata, c.d_rdy, c.bt);
            chk($sformatf("cycle%0d", n), {a, ir, instret}, {c.exp, c.exp_ir, c.exp_cnt});
            if (a.ret) begin
                o_nret++; o_ret_at = n; o_wbs = a.wbs; o_psel = a.psel;
            end
            if (a.pwe) o_npwe++;
            o_rfwe = o_rfwe | a.rwe;
            o_dwe  = o_dwe | a.dwe;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m_ir  = '0;
        m_cnt = '0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        tv[0] = '{I_ADD,        0, 0, 1'b0, 4, 1'b1, 2'd0, 1'b0, 1'b0};
        tv[1] = '{32'h0000A103, 0, 3, 1'b0, 8, 1'b1, 2'd1, 1'b0, 1'b0};
        tv[2] = '{32'h00208463, 0, 0, 1'b1, 3, 1'b0, 2'd0, 1'b1, 1'b0};
        tv[3] = '{32'h00208463, 0, 0, 1'b0, 3, 1'b0, 2'd0, 1'b0, 1'b0};
        tv[4] = '{32'h0080006F, 0, 0, 1'b0, 3, 1'b0, 2'd2, 1'b1, 1'b0};
        tv[5] = '{I_SW,         2, 1, 1'b0, 7, 1'b0, 2'd0, 1'b0, 1'b1};
        tv[6] = '{32'h00000013, 1, 0, 1'b0, 5, 1'b0, 2'd0, 1'b0, 1'b0};
        tv[7] = '{32'h008000EF, 0, 0, 1'b1, 3, 1'b1, 2'd2, 1'b1, 1'b0};
        tv[8] = '{I_ADD,        3, 0, 1'b0, 7, 1'b1, 2'd0, 1'b0, 1'b0};
        tv[9] = '{32'h0000A003, 0, 0, 1'b0, 5, 1'b0, 2'd1, 1'b0, 1'b0};

        rst_n = 1'b0;
        bus.imem_ready = 1'b0;
        bus.imem_rdata = '0;
        bus.dmem_ready = 1'b0;
        branch_taken   = 1'b0;
        m_ir  = '0;
        m_cnt = '0;
        #12;
        chk("reset_state", {cur_out(), ir, instret}, {mk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0), 32'h0, 4'h0});
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        chk("first_fetch_req", cur_out(), mk(3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0));

        for (int t = 0; t < 10; t++) begin
            push_instr(tv[t].instr, tv[t].idly, tv[t].ddly, tv[t].bt);
            run_trace();
            chk($sformatf("v%0d_retire_cycle", t), o_ret_at, tv[t].cyc);
            chk($sformatf("v%0d_one_pulse", t), {o_nret[7:0], o_npwe[7:0]}, 16'h0101);
            chk($sformatf("v%0d_flags", t), {o_rfwe, o_wbs, o_psel, o_dwe},
                {tv[t].rfwe, tv[t].wbs, tv[t].psel, tv[t].dwe});
        end

        for (int k = 0; k < 40; k++) begin
            rins = $urandom;
            rins[6:0] = legal[$urandom_range(0, 5)];
            if ($urandom_range(0, 3) == 0) rins[11:7] = 5'd0;
            push_instr(rins, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
        end
        run_trace();

        // Illegal opcode traps after DECODE; later fetch data is ignored.
        step(1'b1, 32'h0000007F, 1'b0, 1'b0);
        chk("ill_fetch", {a.ireq, a.st}, {1'b1, 3'd0});
        step(1'b0, 32'h0, 1'b0, 1'b0);
        chk("ill_decode", a, mk(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0));
        step(1'b0, 32'h0, 1'b0, 1'b0);
        chk("ill_trap", {a, ir}, {mk(3'd5, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01), 32'h0000007F});
        for (int k = 0; k < 3; k++) begin
            step(1'b1, I_ADD, 1'b1, 1'b1);
            chk("trap_hold", {a, ir}, {mk(3'd5, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01), 32'h0000007F});
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("reset_from_trap", {cur_out(), ir, instret}, {mk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0), 32'h0, 4'h0});
        do_reset();

        // Fetch timeout after four idle cycles.
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 32'h0, 1'b0, 1'b0);
            chk("ifetch_wait", {a.ireq, a.trp, a.st}, {1'b1, 1'b0, 3'd0});
        end
        step(1'b0, 32'h0, 1'b0, 1'b0);
        chk("imem_timeout", a, mk(3'd5, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10));
        do_reset();

        // Store whose data access never completes.
        step(1'b1, I_SW, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 32'h0, 1'b0, 1'b0);
            chk("dmem_wait", {a.dreq, a.dwe, a.trp, a.st}, {1'b1, 1'b1, 1'b0, 3'd3});
        end
        step(1'b0, 32'h0, 1'b0, 1'b0);
        chk("dmem_timeout", a, mk(3'd5, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11));
        do_reset();

        // Ready on the last allowed wait cycle wins over the timeout.
        push_instr(I_SW, 0, 3, 1'b0);
        run_trace();
        chk("ready_at_limit_retire", {o_ret_at[7:0], o_dwe}, {8'd7, 1'b1});
        step(1'b0, 32'h0, 1'b0, 1'b0);
        chk("ready_at_limit_no_trap", {a.trp, a.st, instret}, {1'b0, 3'd0, 4'd1});

        // Reset asserted mid-MEM drops the store request at once.
        step(1'b1, I_SW, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        chk("mem_before_reset", {a.dreq, a.dwe}, 2'b11);
        #2;
        rst_n = 1'b0;
        #1;
        chk("reset_mid_mem", {cur_out(), instret}, {mk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0), 4'h0});
        do_reset();
        #1;
        chk("fetch_after_reset", cur_out(), mk(3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
